sha_mem_responder: RTL

- Host-side companion to the simplified SHA-256 core. It is the memory responder on the core's mem_* initiator interface.
- Owns a word-addressed dual-port RAM: the core reads the message from it and writes the digest back into it.
- Controller FSM loads message words from a host valid/ready stream, pulses start to the core, waits for completion, then streams the 8 digest words out.

---
 rtl/sha_mem_pkg.sv | 20 ++
 rtl/sha_word_ram.sv | 48 ++++
 rtl/sha_mem_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sha_mem_pkg.sv
// Shared types for the SHA-256 memory responder.
//   word_t       : 32-bit RAM / stream word
//   state_t      : controller FSM states
//   DIGEST_WORDS : number of digest words the core writes back (h0..h7)
package sha_mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    LOAD,
    KICK,
    WAIT_LOW,
    WAIT_HIGH,
    DRAIN_RD,
    DRAIN_OUT
  } state_t;

  localparam int unsigned DIGEST_WORDS = 8;

endpackage

// File: rtl/sha_word_ram.sv
// Dual-port synchronous word RAM with registered reads on both ports.
//   clk, rst_n          : clock, async active-low reset (read registers only)
//   a_en                : port A address is in range; when low the write is
//                         dropped and a_rdata loads zero
//   a_we/a_addr/a_wdata : port A write (read-before-write)
//   a_rdata             : port A read data, valid the cycle after a_addr
//   b_re/b_addr         : port B read; b_rdata updates only on b_re
//   b_we/b_wdata        : port B write
// Same-address, same-cycle writes from both ports resolve to port A.
module sha_word_ram
  import sha_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  word_t         a_wdata,
  output word_t         a_rdata,
  input  logic          b_re,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  word_t         b_wdata,
  output word_t         b_rdata
);

  word_t mem [DEPTH];

  // Port A is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_en ? mem[a_addr] : '0;
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// Memory responder / host controller for the simplified SHA-256 core.
// Owns a word RAM: the core (port A) reads the message and writes the digest;
// the controller (port B) loads the message from the host stream and drains
// the 8 digest words back out.
//   clk, reset_n                 : clock (shared with core), async active-low reset
//   mem_we/mem_addr/mem_write_data/mem_read_data : core memory interface
//   start / done                 : one-cycle kick to core / core idle flag
//   in_valid/in_ready/in_data    : message load stream
//   out_valid/out_ready/out_data : digest drain stream, h0 first
//   busy                         : high in every state except LOAD
//   err                          : sticky out-of-range core access
//   timeout                      : sticky watchdog flag (SHA_MEM_TIMEOUT_EN only)
// Optional feature macro: SHA_MEM_TIMEOUT_EN enables the wait-state watchdog.
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned NUM_OF_WORDS   = 20,
  parameter int unsigned MESSAGE_ADDR   = 0,
  parameter int unsigned OUTPUT_ADDR    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  word_t       mem_write_data,
  output word_t       mem_read_data,
  output logic        start,
  input  logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  word_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_data,
  output logic        busy,
  output logic        err
`ifdef SHA_MEM_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sha_mem_responder: DEPTH must be a power of two in 2..65536");
  end
  if (NUM_OF_WORDS == 0 || MESSAGE_ADDR + NUM_OF_WORDS > DEPTH) begin : g_bad_msg
    $error("sha_mem_responder: message region does not fit in RAM");
  end
  if (OUTPUT_ADDR + DIGEST_WORDS > DEPTH) begin : g_bad_out
    $error("sha_mem_responder: digest region does not fit in RAM");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("sha_mem_responder: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t        state, next_state;
  logic   [15:0] k;
  logic   [2:0]  j;
  logic          in_fire, out_fire, last_in, last_out;
  logic          a_en, b_re, b_we;
  logic [AW-1:0] b_addr;

  assign in_fire  = in_valid && in_ready && (state == LOAD);
  assign out_fire = out_valid && out_ready;
  assign last_in  = (k == 16'(NUM_OF_WORDS - 1));
  assign last_out = (j == 3'(DIGEST_WORDS - 1));

  // Core port: 17-bit compare so DEPTH = 65536 still works.
  assign a_en   = ({1'b0, mem_addr} < 17'(DEPTH));
  assign b_we   = in_fire;
  assign b_re   = (state == DRAIN_RD);
  assign b_addr = (state == LOAD) ? AW'(MESSAGE_ADDR + k) : AW'(OUTPUT_ADDR + j);

  sha_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .a_en    (a_en),
    .a_we    (mem_we),
    .a_addr  (mem_addr[AW-1:0]),
    .a_wdata (mem_write_data),
    .a_rdata (mem_read_data),
    .b_re    (b_re),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (in_data),
    .b_rdata (out_data)
  );

`ifdef SHA_MEM_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        waiting, tmo_hit;
  assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign tmo_hit = waiting && (tcnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= waiting ? tcnt + 16'd1 : '0;
      if (tmo_hit) timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      LOAD:      if (in_fire && last_in) next_state = KICK;
      KICK:      next_state = WAIT_LOW;
      WAIT_LOW:  if (!done) next_state = WAIT_HIGH;
      WAIT_HIGH: if (done) next_state = DRAIN_RD;
      DRAIN_RD:  next_state = DRAIN_OUT;
      DRAIN_OUT: if (out_fire) next_state = last_out ? LOAD : DRAIN_RD;
      default:   next_state = LOAD;
    endcase
`ifdef SHA_MEM_TIMEOUT_EN
    if (tmo_hit) next_state = LOAD;
`endif
  end

  // Handshake/status outputs are registered from next_state so they come out
  // of reset low yet still line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      k         <= '0;
      j         <= '0;
      in_ready  <= 1'b0;
      start     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == LOAD);
      start     <= (next_state == KICK);
      out_valid <= (next_state == DRAIN_OUT);
      busy      <= (next_state != LOAD);
      if (!a_en) err <= 1'b1;
      if (in_fire) k <= last_in ? '0 : k + 16'd1;
      if (out_fire) j <= last_out ? '0 : j + 3'd1;
    end
  end

endmodule
